// File: rtl/pixie_rgb_out_if.sv
// pixie_rgb_out_if: Pixie pixel/sync stream in, RGB, syncs and frame-geometry status out.
interface pixie_rgb_out_if #(parameter int CNT_W = 10) ();
  logic             ce_pix;
  logic             video;
  logic             HSync;
  logic             VSync;
  logic             HBlank;
  logic             VBlank;
  logic             video_de;
  logic [23:0]      fg_rgb;
  logic [23:0]      bg_rgb;
  logic [23:0]      border_rgb;
  logic             scanlines;
  logic [7:0]       R;
  logic [7:0]       G;
  logic [7:0]       B;
  logic             HS_out;
  logic             VS_out;
  logic             HBL_out;
  logic             VBL_out;
  logic             DE_out;
  logic [CNT_W-1:0] lines_per_frame;
  logic             locked;
  modport master (
    output ce_pix, video, HSync, VSync, HBlank, VBlank, video_de,
           fg_rgb, bg_rgb, border_rgb, scanlines,
    input  R, G, B, HS_out, VS_out, HBL_out, VBL_out, DE_out, lines_per_frame, locked
  );
  modport slave (
    input  ce_pix, video, HSync, VSync, HBlank, VBlank, video_de,
           fg_rgb, bg_rgb, border_rgb, scanlines,
    output R, G, B, HS_out, VS_out, HBL_out, VBL_out, DE_out, lines_per_frame, locked
  );
endinterface

// File: rtl/pixie_rgb_out.sv
// pixie_rgb_out: 2-stage Pixie pixel-to-RGB back end with scanline dimming and frame lock monitor.
module pixie_rgb_out #(
  parameter int LOCK_FRAMES = 3,
  parameter int CNT_W       = 10
) (
  input logic            clk,
  input logic            reset,
  pixie_rgb_out_if.slave bus
);
  logic [23:0]      col1_q, col1_d, rgb_q, rgb_d;
  logic             hs1_q, vs1_q, hbl1_q, vbl1_q, dim1_q, dim1_d;
  logic             hs2_q, vs2_q, hbl2_q, vbl2_q, de2_q;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, lpf_q, lpf_d;
  logic [3:0]       stb_q, stb_d;
  logic             lck_q, lck_d;
  logic             vs_rise, hb_rise, hb_fall, match;
  always_comb begin
    col1_d  = (bus.HBlank | bus.VBlank) ? 24'h0 :
              bus.video_de ? (bus.video ? bus.fg_rgb : bus.bg_rgb) : bus.border_rgb;
    dim1_d  = bus.scanlines & v_q[0];
    rgb_d   = dim1_q ? {1'b0, col1_q[23:17], 1'b0, col1_q[15:9], 1'b0, col1_q[7:1]} : col1_q;
    // stage-1 registers double as the previous sample for edge detection
    vs_rise = bus.VSync & ~vs1_q;
    hb_rise = bus.HBlank & ~hbl1_q;
    hb_fall = ~bus.HBlank & hbl1_q;
    h_d     = hb_rise ? '0 : (!bus.HBlank && h_q != '1) ? h_q + 1'b1 : h_q;
    v_d     = vs_rise ? '0 : (hb_fall && !bus.VBlank && v_q != '1) ? v_q + 1'b1 : v_q;
    match   = (v_q != '0) && (v_q == lpf_q);
    stb_d   = !vs_rise ? stb_q : !match ? 4'd0 :
              (stb_q == 4'(LOCK_FRAMES)) ? stb_q : stb_q + 4'd1;
    lpf_d   = vs_rise ? v_q : lpf_q;
    lck_d   = vs_rise ? (stb_d == 4'(LOCK_FRAMES)) : lck_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      col1_q <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      hbl1_q <= 1'b0;
      vbl1_q <= 1'b0;
      dim1_q <= 1'b0;
      rgb_q  <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      hbl2_q <= 1'b0;
      vbl2_q <= 1'b0;
      de2_q  <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      lpf_q  <= '0;
      stb_q  <= '0;
      lck_q  <= 1'b0;
    end else if (bus.ce_pix) begin
      col1_q <= col1_d;
      hs1_q  <= bus.HSync;
      vs1_q  <= bus.VSync;
      hbl1_q <= bus.HBlank;
      vbl1_q <= bus.VBlank;
      dim1_q <= dim1_d;
      rgb_q  <= rgb_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      hbl2_q <= hbl1_q;
      vbl2_q <= vbl1_q;
      de2_q  <= ~(hbl1_q | vbl1_q);
      h_q    <= h_d;
      v_q    <= v_d;
      lpf_q  <= lpf_d;
      stb_q  <= stb_d;
      lck_q  <= lck_d;
    end
  end
  assign bus.R               = rgb_q[23:16];
  assign bus.G               = rgb_q[15:8];
  assign bus.B               = rgb_q[7:0];
  assign bus.HS_out          = hs2_q;
  assign bus.VS_out          = vs2_q;
  assign bus.HBL_out         = hbl2_q;
  assign bus.VBL_out         = vbl2_q;
  assign bus.DE_out          = de2_q;
  assign bus.lines_per_frame = lpf_q;
  assign bus.locked          = lck_q;
endmodule

// File: tb/tb_pixie_rgb_out.sv
// tb_pixie_rgb_out: directed vector table plus hand sequences for latency, lock and reset behaviour.
module tb_pixie_rgb_out;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  pixie_rgb_out_if #(.CNT_W(10)) bus ();
  pixie_rgb_out #(.LOCK_FRAMES(3), .CNT_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic        video, de, hbl, vbl, scan, odd;
    logic [23:0] rgb;
  } vec_t;
  localparam logic [23:0] FG = 24'hFF8040, BG = 24'h112233, BD = 24'h102030;
  vec_t vt[11];
  int total = 0, passed = 0;
  logic vpar = 1'b0, prev_hbl = 1'b0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [39:0] all_out();
    return {bus.R, bus.G, bus.B, bus.HS_out, bus.VS_out, bus.HBL_out, bus.VBL_out,
            bus.DE_out, bus.lines_per_frame, bus.locked};
  endfunction
  task automatic line_step();
    bus.VBlank = 1'b0;
    bus.HBlank = 1'b1;
    tick();
    bus.HBlank = 1'b0;
    tick();
    vpar     = ~vpar;
    prev_hbl = 1'b0;
  endtask
  task automatic apply(input vec_t v, input int idx);
    while ((vpar ^ (prev_hbl & ~v.hbl & ~v.vbl)) != v.odd) line_step();
    vpar          = vpar ^ (prev_hbl & ~v.hbl & ~v.vbl);
    prev_hbl      = v.hbl;
    bus.video     = v.video;
    bus.video_de  = v.de;
    bus.HBlank    = v.hbl;
    bus.VBlank    = v.vbl;
    bus.scanlines = v.scan;
    repeat (3) tick();
    chk($sformatf("vec%0d", idx), {bus.R, bus.G, bus.B, bus.HBL_out, bus.VBL_out, bus.DE_out},
        {v.rgb, v.hbl, v.vbl, ~(v.hbl | v.vbl)});
  endtask
  task automatic lines(input int n);
    bus.VSync  = 1'b0;
    bus.VBlank = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.HBlank = 1'b1;
      tick();
      bus.HBlank = 1'b0;
      tick();
    end
    bus.HBlank = 1'b1;
    bus.VBlank = 1'b1;
    tick();
  endtask
  task automatic vedge();
    bus.VSync  = 1'b1;
    bus.HBlank = 1'b1;
    bus.VBlank = 1'b1;
    repeat (5) tick();
    bus.VSync = 1'b0;
    tick();
  endtask
  initial begin
    vt[0]  = '{1, 1, 0, 0, 0, 0, FG};
    vt[1]  = '{0, 1, 0, 0, 0, 0, BG};
    vt[2]  = '{0, 0, 0, 0, 0, 0, BD};
    vt[3]  = '{0, 0, 0, 0, 1, 1, 24'h081018};
    vt[4]  = '{0, 0, 0, 0, 1, 0, BD};
    vt[5]  = '{1, 1, 0, 0, 1, 1, 24'h7F4020};
    vt[6]  = '{0, 1, 0, 0, 1, 1, 24'h081119};
    vt[7]  = '{1, 1, 1, 0, 0, 0, 24'h0};
    vt[8]  = '{0, 0, 0, 1, 1, 1, 24'h0};
    vt[9]  = '{1, 1, 1, 1, 1, 0, 24'h0};
    vt[10] = '{1, 1, 0, 0, 1, 0, FG};
    bus.ce_pix = 1'b1; bus.video = 1'b1; bus.video_de = 1'b1; bus.HSync = 1'b0; bus.VSync = 1'b0;
    bus.HBlank = 1'b0; bus.VBlank = 1'b0; bus.scanlines = 1'b0;
    bus.fg_rgb = FG; bus.bg_rgb = BG; bus.border_rgb = BD;
    repeat (2) tick();
    chk("reset_all", {24'h0, all_out()}, 64'h0);
    reset = 1'b1;
    tick();
    chk("lat1", {40'h0, bus.R, bus.G, bus.B}, 64'h0);
    tick();
    chk("lat2", {40'h0, bus.R, bus.G, bus.B}, {40'h0, FG});
    for (int i = 0; i < 11; i++) apply(vt[i], i);
    bus.HBlank = 1'b0; bus.VBlank = 1'b0; bus.video = 1'b0; bus.video_de = 1'b1;
    bus.scanlines = 1'b0;
    repeat (3) tick();
    begin
      int n = 0;
      bus.ce_pix = 1'b0; bus.video = 1'b1; bus.HSync = 1'b1; bus.VSync = 1'b1;
      for (int i = 0; i < 12; i++) begin
        bus.ce_pix = (i % 4 == 0);
        tick();
        if (i % 4 == 0) n++;
        chk($sformatf("ce_div%0d", i), {38'h0, bus.HS_out, bus.VS_out, bus.R, bus.G, bus.B},
            (n >= 2) ? {38'h0, 2'b11, FG} : {38'h0, 2'b00, BG});
      end
      bus.ce_pix = 1'b1; bus.HSync = 1'b0; bus.VSync = 1'b0;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      lines(128);
      vedge();
      chk($sformatf("lock128_e%0d", e), {53'h0, bus.lines_per_frame, bus.locked},
          {53'h0, 10'd128, e == 3});
    end
    lines(127);
    bus.VSync = 1'b1; bus.HBlank = 1'b1; bus.VBlank = 1'b1;
    tick();
    chk("unlock_at_edge", {53'h0, bus.lines_per_frame, bus.locked}, {53'h0, 10'd127, 1'b0});
    repeat (3) tick();
    bus.VSync = 1'b0;
    tick();
    for (int e = 0; e < 3; e++) begin
      lines(127);
      vedge();
      chk($sformatf("relock_e%0d", e), {53'h0, bus.lines_per_frame, bus.locked},
          {53'h0, 10'd127, e == 2});
    end
    bus.HBlank = 1'b0; bus.VBlank = 1'b0; bus.video = 1'b1; bus.HSync = 1'b1;
    repeat (3) tick();
    chk("pre_reset_locked", {63'h0, bus.locked}, 64'h1);
    reset = 1'b0;
    tick();
    chk("midline_reset", {24'h0, all_out()}, 64'h0);
    reset = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
